// File: rtl/mem_access_pkg.sv
// Shared types and constants for the CPU-side memory access unit.
// Imported by the access FSM and its load-extension helper.
package mem_access_pkg;

  localparam int ADDR_W_DEF = 18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_CAPTURE,
    S_RESP
  } state_e;

  localparam logic ACC_LOAD  = 1'b0;
  localparam logic ACC_STORE = 1'b1;
  localparam logic ACC_WORD  = 1'b0;
  localparam logic ACC_BYTE  = 1'b1;

  typedef struct packed {
    logic write;
    logic byte_op;
    logic sgn;
  } acc_t;

  function automatic logic misaligned(
    input logic       byte_op,
    input logic [1:0] lo
  );
    return (byte_op == ACC_WORD) && (lo != 2'b00);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects word or low byte of memory read data, with optional
// sign extension of the byte.
module load_extend #(
  parameter int DW = 32
) (
  input  logic          byte_op,
  input  logic          sgn,
  input  logic [DW-1:0] raw,
  output logic [DW-1:0] data
);

  logic ext;

  assign ext  = raw[7] & sgn;
  assign data = byte_op ? {{(DW-8){ext}}, raw[7:0]} : raw;

endmodule

// File: rtl/mem_access_unit.sv
// Sequences one CPU load/store at a time onto the memory block
// through SETUP/STROBE/CAPTURE, then holds the response.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_memRead,
  output logic              mem_memWrite,
  output logic              mem_byteOperations,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_e            state;
  acc_t              acc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [DATA_W-1:0] ld_data;
  logic              mem_active;
  logic              bad;

  load_extend #(.DW(DATA_W)) u_ext (
    .byte_op (acc_q.byte_op),
    .sgn     (acc_q.sgn),
    .raw     (mem_read_data),
    .data    (ld_data)
  );

  assign bad = misaligned(req_byte, req_addr[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      acc_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            acc_q.write   <= req_write;
            acc_q.byte_op <= req_byte;
            acc_q.sgn     <= req_signed;
            addr_q        <= req_addr;
            wdata_q       <= req_wdata;
            rdata_q       <= '0;
            err_q         <= bad;
            state         <= bad ? S_RESP : S_SETUP;
          end
        end
        S_SETUP:  state <= S_STROBE;
        S_STROBE: state <= S_CAPTURE;
        S_CAPTURE: begin
          // Stores report zero data, so only loads capture.
          if (acc_q.write == ACC_LOAD) begin
            rdata_q <= ld_data;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_active = (state == S_SETUP)
                    | (state == S_STROBE)
                    | (state == S_CAPTURE);

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & err_q;

  assign mem_address        = mem_active ? addr_q : '0;
  assign mem_write_data     = mem_active ? wdata_q : '0;
  assign mem_byteOperations = mem_active & acc_q.byte_op;

  // Strobes decode straight from state so reset kills them at once.
  assign mem_memRead  = (state == S_STROBE)
                      & (acc_q.write == ACC_LOAD);
  assign mem_memWrite = (state == S_STROBE)
                      & (acc_q.write == ACC_STORE);

endmodule
